// File: rtl/neuron_frame_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// neuron_frame_sequencer_pkg
//   Shared types and sizes for the 7x7 classifier frame sequencer.
//   - SEQ_NUM_ROWS / SEQ_ROW_W : frame geometry (7 rows of 7 x 8-bit pixels)
//   - SEQ_NUM_CLASSES          : number of class scores from neuron_unit
//   - seq_state_t              : sequencer FSM states
//   - score_t                  : signed 32-bit class score
// -----------------------------------------------------------------------------
package neuron_frame_sequencer_pkg;

   localparam int SEQ_NUM_ROWS    = 7;
   localparam int SEQ_ROW_W       = 56;
   localparam int SEQ_NUM_CLASSES = 4;
   localparam int SEQ_ROW_CNT_W   = $clog2(SEQ_NUM_ROWS);

   typedef enum logic [1:0] {
      SEQ_FILL   = 2'd0,
      SEQ_RUN    = 2'd1,
      SEQ_RESULT = 2'd2
   } seq_state_t;

   typedef logic signed [31:0]   score_t;
   typedef logic [SEQ_ROW_W-1:0] row_t;

endpackage

// File: rtl/neuron_frame_sequencer_argmax4.sv
// -----------------------------------------------------------------------------
// argmax4
//   Combinational argmax over four signed 32-bit class scores.
//   Ports:
//     score_0..score_3 in  signed 32  class scores
//     idx              out 2          index of the largest score
//     max_score        out signed 32  value of the largest score
//   Two-level compare tree. The higher-indexed side wins only when strictly
//   greater, so ties resolve to the lowest index (all-equal -> class 0).
// -----------------------------------------------------------------------------
module argmax4
   import neuron_frame_sequencer_pkg::*;
(
   input  logic signed [31:0] score_0,
   input  logic signed [31:0] score_1,
   input  logic signed [31:0] score_2,
   input  logic signed [31:0] score_3,
   output logic [1:0]         idx,
   output logic signed [31:0] max_score
);

   score_t     max_01;
   score_t     max_23;
   logic [1:0] idx_01;
   logic [1:0] idx_23;

   always_comb begin
      // NOTE: every output of a combinational block gets a value on every
      // path (defaults first), otherwise synthesis infers a latch.
      max_01    = score_0;
      idx_01    = 2'd0;
      max_23    = score_2;
      idx_23    = 2'd2;
      max_score = '0;
      idx       = 2'd0;

      if (score_1 > score_0) begin
         max_01 = score_1;
         idx_01 = 2'd1;
      end
      if (score_3 > score_2) begin
         max_23 = score_3;
         idx_23 = 2'd3;
      end

      if (max_23 > max_01) begin
         max_score = max_23;
         idx       = idx_23;
      end else begin
         max_score = max_01;
         idx       = idx_01;
      end
   end

endmodule

// File: rtl/neuron_frame_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_frame_sequencer
//   Collects a 7-row frame for neuron_unit, holds it stable while the network
//   runs for NET_LATENCY cycles, captures the four class scores and emits the
//   argmax class on a valid/ready result port. One frame in flight.
//   Ports:
//     clk, reset            clock / synchronous active-high reset
//     row_in, row_sof,      row input (pixel 0 in [55:48]); sof marks row 0
//     row_valid, row_ready  row handshake; ready low outside FILL
//     line_0..6_out         buffered frame rows to neuron_unit
//     net_de                neuron_unit data enable, high for the whole RUN
//     symbol_0..3           signed class scores from neuron_unit
//     class_out, score_out  winning class index and its score
//     result_valid/ready    result handshake
// -----------------------------------------------------------------------------
module neuron_frame_sequencer
   import neuron_frame_sequencer_pkg::*;
#(
   parameter int NET_LATENCY = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [55:0] row_in,
   input  logic        row_sof,
   input  logic        row_valid,
   output logic        row_ready,
   output logic [55:0] line_0_out,
   output logic [55:0] line_1_out,
   output logic [55:0] line_2_out,
   output logic [55:0] line_3_out,
   output logic [55:0] line_4_out,
   output logic [55:0] line_5_out,
   output logic [55:0] line_6_out,
   output logic        net_de,
   input  logic [31:0] symbol_0,
   input  logic [31:0] symbol_1,
   input  logic [31:0] symbol_2,
   input  logic [31:0] symbol_3,
   output logic [1:0]  class_out,
   output logic [31:0] score_out,
   output logic        result_valid,
   input  logic        result_ready
);

   localparam int LAT_W = (NET_LATENCY > 1) ? $clog2(NET_LATENCY) : 1;
   localparam logic [LAT_W-1:0]         LAT_LAST = LAT_W'(NET_LATENCY - 1);
   localparam logic [SEQ_ROW_CNT_W-1:0] ROW_LAST = SEQ_ROW_CNT_W'(SEQ_NUM_ROWS - 1);
   localparam logic [SEQ_ROW_CNT_W-1:0] ROW_ONE  = SEQ_ROW_CNT_W'(1);

   seq_state_t               state_q,        state_d;
   logic [SEQ_ROW_CNT_W-1:0] row_cnt_q,      row_cnt_d;
   logic [LAT_W-1:0]         lat_cnt_q,      lat_cnt_d;
   row_t                     line_q [SEQ_NUM_ROWS];
   row_t                     line_d [SEQ_NUM_ROWS];
   score_t                   cap_q  [SEQ_NUM_CLASSES];
   score_t                   cap_d  [SEQ_NUM_CLASSES];
   logic                     row_ready_q,    row_ready_d;
   logic                     net_de_q,       net_de_d;
   logic                     result_valid_q, result_valid_d;
   logic [1:0]               class_q,        class_d;
   score_t                   score_q,        score_d;

   logic [1:0] am_idx;
   score_t     am_max;

   argmax4 u_argmax4 (
      .score_0   (cap_q[0]),
      .score_1   (cap_q[1]),
      .score_2   (cap_q[2]),
      .score_3   (cap_q[3]),
      .idx       (am_idx),
      .max_score (am_max)
   );

   always_comb begin
      state_d        = state_q;
      row_cnt_d      = row_cnt_q;
      lat_cnt_d      = lat_cnt_q;
      line_d         = line_q;
      cap_d          = cap_q;
      result_valid_d = result_valid_q;
      class_d        = class_q;
      score_d        = score_q;

      case (state_q)
         SEQ_FILL: begin
            if (row_valid && row_ready_q) begin
               if (row_sof) begin
                  // A new start-of-frame always restarts the frame; any
                  // partially collected rows are simply overwritten later.
                  line_d[0] = row_in;
                  row_cnt_d = ROW_ONE;
               end else if (row_cnt_q != '0) begin
                  for (int k = 1; k < SEQ_NUM_ROWS; k++) begin
                     if (row_cnt_q == SEQ_ROW_CNT_W'(k)) line_d[k] = row_in;
                  end
                  if (row_cnt_q == ROW_LAST) begin
                     state_d   = SEQ_RUN;
                     row_cnt_d = '0;
                     lat_cnt_d = '0;
                  end else begin
                     row_cnt_d = row_cnt_q + ROW_ONE;
                  end
               end
               // row_sof=0 with row_cnt=0: no frame start seen, row dropped.
            end
         end

         SEQ_RUN: begin
            if (lat_cnt_q == LAT_LAST) begin
               cap_d[0] = symbol_0;
               cap_d[1] = symbol_1;
               cap_d[2] = symbol_2;
               cap_d[3] = symbol_3;
               lat_cnt_d = '0;
               state_d   = SEQ_RESULT;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end

         SEQ_RESULT: begin
            // First RESULT cycle registers the argmax of the captured scores;
            // afterwards the result is held until the consumer takes it.
            if (!result_valid_q) begin
               result_valid_d = 1'b1;
               class_d        = am_idx;
               score_d        = am_max;
            end else if (result_ready) begin
               result_valid_d = 1'b0;
               state_d        = SEQ_FILL;
            end
         end

         default: state_d = SEQ_FILL;
      endcase

      // Registered outputs follow the next state so they line up with it.
      row_ready_d = (state_d == SEQ_FILL);
      net_de_d    = (state_d == SEQ_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the line and capture registers are reset as well, because
         // line_*_out are visible outputs that must read zero after reset.
         state_q        <= SEQ_FILL;
         row_cnt_q      <= '0;
         lat_cnt_q      <= '0;
         line_q         <= '{default: '0};
         cap_q          <= '{default: '0};
         row_ready_q    <= 1'b0;
         net_de_q       <= 1'b0;
         result_valid_q <= 1'b0;
         class_q        <= 2'd0;
         score_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // present before the edge, independent of statement order.
         state_q        <= state_d;
         row_cnt_q      <= row_cnt_d;
         lat_cnt_q      <= lat_cnt_d;
         line_q         <= line_d;
         cap_q          <= cap_d;
         row_ready_q    <= row_ready_d;
         net_de_q       <= net_de_d;
         result_valid_q <= result_valid_d;
         class_q        <= class_d;
         score_q        <= score_d;
      end
   end

   assign row_ready    = row_ready_q;
   assign net_de       = net_de_q;
   assign result_valid = result_valid_q;
   assign class_out    = class_q;
   assign score_out    = score_q;
   assign line_0_out   = line_q[0];
   assign line_1_out   = line_q[1];
   assign line_2_out   = line_q[2];
   assign line_3_out   = line_q[3];
   assign line_4_out   = line_q[4];
   assign line_5_out   = line_q[5];
   assign line_6_out   = line_q[6];

endmodule

// File: tb/tb_neuron_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neuron_frame_sequencer
//   Directed self-checking bench for neuron_frame_sequencer (NET_LATENCY=4).
// -----------------------------------------------------------------------------
module tb_neuron_frame_sequencer;

   localparam int NET_LATENCY = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [55:0] row_in;
   logic        row_sof;
   logic        row_valid;
   logic        row_ready;
   logic [55:0] line_0_out, line_1_out, line_2_out, line_3_out;
   logic [55:0] line_4_out, line_5_out, line_6_out;
   logic        net_de;
   logic [31:0] symbol_0, symbol_1, symbol_2, symbol_3;
   logic [1:0]  class_out;
   logic [31:0] score_out;
   logic        result_valid;
   logic        result_ready;

   int n_cmp = 0;
   int n_err = 0;
   int n_hs  = 0;
   logic [31:0] hs_scores[$];

   always #5 clk = ~clk;

   neuron_frame_sequencer #(.NET_LATENCY(NET_LATENCY)) dut (
      .clk          (clk),
      .reset        (reset),
      .row_in       (row_in),
      .row_sof      (row_sof),
      .row_valid    (row_valid),
      .row_ready    (row_ready),
      .line_0_out   (line_0_out),
      .line_1_out   (line_1_out),
      .line_2_out   (line_2_out),
      .line_3_out   (line_3_out),
      .line_4_out   (line_4_out),
      .line_5_out   (line_5_out),
      .line_6_out   (line_6_out),
      .net_de       (net_de),
      .symbol_0     (symbol_0),
      .symbol_1     (symbol_1),
      .symbol_2     (symbol_2),
      .symbol_3     (symbol_3),
      .class_out    (class_out),
      .score_out    (score_out),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   // Result handshakes seen on the port, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset && result_valid && result_ready) begin
         n_hs++;
         hs_scores.push_back(score_out);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [55:0] mk_row(input int fid, input int k);
      return {8'(fid), 8'(k), 40'h01_2345_6789 + 40'(k * 3)};
   endfunction

   function automatic logic [55:0] get_line(input int k);
      case (k)
         0: return line_0_out;
         1: return line_1_out;
         2: return line_2_out;
         3: return line_3_out;
         4: return line_4_out;
         5: return line_5_out;
         default: return line_6_out;
      endcase
   endfunction

   task automatic set_scores(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
      symbol_0 = a;
      symbol_1 = b;
      symbol_2 = c;
      symbol_3 = d;
   endtask

   task automatic send_row(input logic [55:0] r, input logic sof);
      int w = 0;
      row_in    = r;
      row_sof   = sof;
      row_valid = 1'b1;
      while (!row_ready && w < 100) begin
         step();
         w++;
      end
      if (w >= 100) check("row_ready_timeout", 64'(row_ready), 64'd1);
      step();
      row_valid = 1'b0;
      row_sof   = 1'b0;
   endtask

   task automatic send_frame(input int fid, input int nrows);
      for (int k = 0; k < nrows; k++) send_row(mk_row(fid, k), (k == 0));
   endtask

   // Called right after the last row: sample index 0 follows acceptance edge T.
   task automatic wait_result(output int de_n, output int lat);
      de_n = 0;
      lat  = -1;
      for (int i = 0; i <= 50; i++) begin
         if (result_valid) begin
            lat = i;
            break;
         end
         if (net_de) de_n++;
         step();
      end
   endtask

   task automatic take_result(input string tag, input logic [1:0] cls, input logic [31:0] sc);
      check({tag, "_class"}, 64'(class_out), 64'(cls));
      check({tag, "_score"}, 64'(score_out), 64'(sc));
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      check({tag, "_valid_drop"}, 64'(result_valid), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      int de_n, lat, bad, hs0;
      logic [31:0] t6_sc [3][4];
      logic [1:0]  t6_cls[3];
      logic [31:0] t6_max[3];
      logic [31:0] got;

      reset        = 1'b1;
      row_in       = '0;
      row_sof      = 1'b0;
      row_valid    = 1'b0;
      result_ready = 1'b0;
      set_scores(0, 0, 0, 0);
      step();
      step();

      // Reset state
      check("rst_row_ready", 64'(row_ready), 64'd0);
      check("rst_net_de", 64'(net_de), 64'd0);
      check("rst_result_valid", 64'(result_valid), 64'd0);
      check("rst_class", 64'(class_out), 64'd0);
      check("rst_score", 64'(score_out), 64'd0);
      check("rst_line0", 64'(line_0_out), 64'd0);
      check("rst_line6", 64'(line_6_out), 64'd0);
      reset = 1'b0;
      step();
      check("post_rst_row_ready", 64'(row_ready), 64'd1);

      // 1: basic frame, latency and line contents
      set_scores(5, 9, -3, 2);
      send_frame(1, 7);
      wait_result(de_n, lat);
      check("t1_latency", 64'(lat), 64'(NET_LATENCY + 1));
      check("t1_de_width", 64'(de_n), 64'(NET_LATENCY));
      check("t1_row_ready_busy", 64'(row_ready), 64'd0);
      for (int k = 0; k < 7; k++)
         check($sformatf("t1_line%0d", k), 64'(get_line(k)), 64'(mk_row(1, k)));
      take_result("t1", 2'd1, 32'd9);

      // 2: signed compare and tie-breaking
      set_scores(-8, -2, -2, -9);
      send_frame(2, 7);
      wait_result(de_n, lat);
      take_result("t2_neg_tie", 2'd1, 32'hFFFF_FFFE);
      set_scores(7, 7, 7, 7);
      send_frame(3, 7);
      wait_result(de_n, lat);
      take_result("t2_all_equal", 2'd0, 32'd7);
      set_scores(32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 3);
      send_frame(4, 7);
      wait_result(de_n, lat);
      take_result("t2_extremes", 2'd2, 32'h7FFF_FFFF);

      // 3: result held under back-pressure, offered rows ignored
      set_scores(0, 0, 0, 4);
      send_frame(5, 7);
      wait_result(de_n, lat);
      check("t3_latency", 64'(lat), 64'(NET_LATENCY + 1));
      row_in    = mk_row(9, 0);
      row_sof   = 1'b1;
      row_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (class_out !== 2'd3 || score_out !== 32'd4 || result_valid !== 1'b1 ||
             row_ready !== 1'b0) bad++;
      end
      check("t3_hold_stable", 64'(bad), 64'd0);
      check("t3_row_not_stored", 64'(line_0_out), 64'(mk_row(5, 0)));
      row_valid    = 1'b0;
      row_sof      = 1'b0;
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      check("t3_valid_drop", 64'(result_valid), 64'd0);
      check("t3_back_to_fill", 64'(row_ready), 64'd1);

      // 4: rows without sof after reset are dropped; sof restarts a frame
      do_reset();
      send_row(mk_row(7, 0), 1'b0);
      for (int k = 1; k < 7; k++) send_row(mk_row(7, k), 1'b0);
      step();
      check("t4_no_run_without_sof", 64'(net_de), 64'd0);
      check("t4_nosof_line1", 64'(line_1_out), 64'd0);
      hs0 = n_hs;
      set_scores(3, 1, 3, 0);
      send_frame(10, 4);
      send_frame(11, 7);
      wait_result(de_n, lat);
      check("t4_latency", 64'(lat), 64'(NET_LATENCY + 1));
      check("t4_line0_new", 64'(line_0_out), 64'(mk_row(11, 0)));
      check("t4_line4_new", 64'(line_4_out), 64'(mk_row(11, 4)));
      take_result("t4", 2'd0, 32'd3);
      for (int i = 0; i < 12; i++) step();
      check("t4_one_result", 64'(n_hs - hs0), 64'd1);

      // 5: reset during RUN discards the frame
      set_scores(1, 2, 3, 4);
      send_frame(12, 7);
      step();
      step();
      check("t5_in_run", 64'(net_de), 64'd1);
      reset = 1'b1;
      step();
      check("t5_net_de_off", 64'(net_de), 64'd0);
      check("t5_line0_cleared", 64'(line_0_out), 64'd0);
      reset = 1'b0;
      hs0 = n_hs;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (result_valid !== 1'b0) bad++;
      end
      check("t5_no_result", 64'(bad), 64'd0);
      set_scores(4, 3, 2, 1);
      send_frame(13, 7);
      wait_result(de_n, lat);
      check("t5_latency", 64'(lat), 64'(NET_LATENCY + 1));
      take_result("t5", 2'd0, 32'd4);
      check("t5_one_result", 64'(n_hs - hs0), 64'd1);

      // 6: back-to-back frames with result_ready tied high
      t6_sc[0] = '{32'd10, 32'd20, 32'd30, 32'd40};
      t6_sc[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
      t6_sc[2] = '{32'd0, 32'd100, 32'd100, 32'hFFFF_FF9C};
      t6_cls   = '{2'd3, 2'd0, 2'd1};
      t6_max   = '{32'd40, 32'hFFFF_FFFF, 32'd100};
      hs_scores.delete();
      result_ready = 1'b1;
      for (int f = 0; f < 3; f++) begin
         set_scores(t6_sc[f][0], t6_sc[f][1], t6_sc[f][2], t6_sc[f][3]);
         send_frame(20 + f, 7);
         wait_result(de_n, lat);
         check($sformatf("t6_de_width_%0d", f), 64'(de_n), 64'(NET_LATENCY));
         check($sformatf("t6_class_%0d", f), 64'(class_out), 64'(t6_cls[f]));
         check($sformatf("t6_score_%0d", f), 64'(score_out), 64'(t6_max[f]));
         step();
      end
      result_ready = 1'b0;
      step();
      check("t6_result_count", 64'(hs_scores.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         got = (i < hs_scores.size()) ? hs_scores[i] : 32'hDEAD_BEEF;
         check($sformatf("t6_order_%0d", i), 64'(got), 64'(t6_max[i]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
